// File: rtl/ps2_voice_alloc.sv
// Polyphonic voice allocator: parses a PS/2 scan-code stream and assigns held keys
// to a fixed pool of voice slots, stealing the least-recently-allocated slot when full.
module ps2_voice_alloc #(
  parameter int VOICES = 4
) (
  input  logic                  clk,
  input  logic                  clrn,
  input  logic [7:0]            data,
  input  logic                  ready,
  input  logic                  all_off,
  output logic [8*VOICES-1:0]   voice_key,
  output logic [VOICES-1:0]     voice_on,
  output logic                  evt,
  output logic [2:0]            evt_slot,
  output logic                  evt_on,
  output logic [3:0]            held
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BRK    = 2'd1,
    EXT    = 2'd2,
    EXTBRK = 2'd3
  } state_t;

  localparam logic [2:0] OLDEST = 3'(VOICES - 1);

  function automatic logic [3:0] popcount(input logic [VOICES-1:0] v);
    logic [3:0] cnt;
    cnt = 4'd0;
    for (int i = 0; i < VOICES; i++) begin
      cnt = cnt + {3'b000, v[i]};
    end
    return cnt;
  endfunction

  state_t                   state_r, state_s;
  logic [VOICES-1:0][7:0]   key_r, key_s;
  logic [VOICES-1:0][2:0]   rank_r, rank_s;
  logic [VOICES-1:0]        on_r, on_s;
  logic                     evt_r, evt_s;
  logic [2:0]               evt_slot_r, evt_slot_s;
  logic                     evt_on_r, evt_on_s;
  logic [3:0]               held_r;

  logic                     match_hit_s, free_hit_s;
  logic [2:0]               match_idx_s, free_idx_s, lru_idx_s, alloc_idx_s, alloc_rank_s;
  logic                     make_s, brk_s;

  // Slot search: sounding-key match, lowest free slot, oldest slot and its rank
  always_comb begin
    match_hit_s  = 1'b0;
    match_idx_s  = 3'd0;
    free_hit_s   = 1'b0;
    free_idx_s   = 3'd0;
    lru_idx_s    = 3'd0;
    alloc_rank_s = 3'd0;
    // Scan downward so the lowest index wins
    for (int i = VOICES - 1; i >= 0; i--) begin
      match_hit_s = (on_r[i] && (key_r[i] == data)) ? 1'b1   : match_hit_s;
      match_idx_s = (on_r[i] && (key_r[i] == data)) ? 3'(i)  : match_idx_s;
      free_hit_s  = (!on_r[i]) ? 1'b1  : free_hit_s;
      free_idx_s  = (!on_r[i]) ? 3'(i) : free_idx_s;
      lru_idx_s   = (rank_r[i] == OLDEST) ? 3'(i) : lru_idx_s;
    end
    alloc_idx_s = free_hit_s ? free_idx_s : lru_idx_s;
    for (int i = 0; i < VOICES; i++) begin
      alloc_rank_s = (3'(i) == alloc_idx_s) ? rank_r[i] : alloc_rank_s;
    end
  end

  // Parser transition and next voice/rank/event state for the accepted byte
  always_comb begin
    state_s    = state_r;
    key_s      = key_r;
    rank_s     = rank_r;
    on_s       = on_r;
    evt_s      = 1'b0;
    evt_slot_s = evt_slot_r;
    evt_on_s   = evt_on_r;
    make_s     = 1'b0;
    brk_s      = 1'b0;

    if (all_off) begin
      state_s = IDLE;
      on_s    = '0;
    end else if (ready) begin
      case (state_r)
        IDLE: begin
          if (data == 8'hF0) begin
            state_s = BRK;
          end else if (data == 8'hE0) begin
            state_s = EXT;
          end else if (data == 8'h00) begin
            state_s = IDLE;
          end else begin
            make_s = 1'b1;
          end
        end
        BRK: begin
          state_s = IDLE;
          brk_s   = 1'b1;
        end
        EXT:     state_s = (data == 8'hF0) ? EXTBRK : IDLE;
        EXTBRK:  state_s = IDLE;
        default: state_s = IDLE;
      endcase
    end else begin
      state_s = state_r;
    end

    // A repeated make of a sounding key is typematic and leaves everything alone
    if (make_s && !match_hit_s) begin
      for (int i = 0; i < VOICES; i++) begin
        if (3'(i) == alloc_idx_s) begin
          key_s[i]  = data;
          on_s[i]   = 1'b1;
          rank_s[i] = 3'd0;
        end else if (rank_r[i] < alloc_rank_s) begin
          rank_s[i] = rank_r[i] + 3'd1;
        end else begin
          rank_s[i] = rank_r[i];
        end
      end
      evt_s      = 1'b1;
      evt_slot_s = alloc_idx_s;
      evt_on_s   = 1'b1;
    end else if (brk_s && match_hit_s) begin
      for (int i = 0; i < VOICES; i++) begin
        on_s[i] = (3'(i) == match_idx_s) ? 1'b0 : on_r[i];
      end
      evt_s      = 1'b1;
      evt_slot_s = match_idx_s;
      evt_on_s   = 1'b0;
    end else begin
      evt_s = 1'b0;
    end
  end

  // State registers; ranks start as the identity permutation
  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      state_r    <= IDLE;
      key_r      <= '0;
      on_r       <= '0;
      evt_r      <= 1'b0;
      evt_slot_r <= 3'd0;
      evt_on_r   <= 1'b0;
      held_r     <= 4'd0;
      for (int i = 0; i < VOICES; i++) begin
        rank_r[i] <= 3'(i);
      end
    end else begin
      state_r    <= state_s;
      key_r      <= key_s;
      rank_r     <= rank_s;
      on_r       <= on_s;
      evt_r      <= evt_s;
      evt_slot_r <= evt_slot_s;
      evt_on_r   <= evt_on_s;
      held_r     <= popcount(on_s);
    end
  end

  assign voice_key = key_r;
  assign voice_on  = on_r;
  assign evt       = evt_r;
  assign evt_slot  = evt_slot_r;
  assign evt_on    = evt_on_r;
  assign held      = held_r;

endmodule

// File: tb/tb_ps2_voice_alloc.sv
// Directed bench for ps2_voice_alloc (VOICES=4) with hand-computed expectations.
module tb_ps2_voice_alloc;

  logic        clk = 1'b0;
  logic        clrn = 1'b1;
  logic [7:0]  data = 8'h00;
  logic        ready = 1'b0;
  logic        all_off = 1'b0;
  logic [31:0] voice_key;
  logic [3:0]  voice_on;
  logic        evt;
  logic [2:0]  evt_slot;
  logic        evt_on;
  logic [3:0]  held;

  int total = 0;
  int bad = 0;

  ps2_voice_alloc #(.VOICES(4)) dut (
    .clk(clk), .clrn(clrn), .data(data), .ready(ready), .all_off(all_off),
    .voice_key(voice_key), .voice_on(voice_on), .evt(evt),
    .evt_slot(evt_slot), .evt_on(evt_on), .held(held)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    clrn = 1'b1; ready = 1'b0; all_off = 1'b0; data = 8'h00;
    @(negedge clk);
    clrn = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    data = b; ready = 1'b1;
    @(posedge clk);
    #1 ready = 1'b0;
  endtask

  task automatic panic(input logic with_ready, input logic [7:0] b);
    @(negedge clk);
    all_off = 1'b1; ready = with_ready; data = b;
    @(posedge clk);
    #1 all_off = 1'b0; ready = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    do_reset();
    check("rst_on",   32'(voice_on), 32'h0);
    check("rst_key",  voice_key,     32'h0);
    check("rst_held", 32'(held),     32'h0);
    check("rst_evt",  32'(evt),      32'h0);
    check("rst_slot", 32'(evt_slot), 32'h0);
    check("rst_evon", 32'(evt_on),   32'h0);

    // Two makes fill slots 0 and 1
    send(8'h1C);
    check("m1_evt",  32'(evt),      32'h1);
    check("m1_slot", 32'(evt_slot), 32'h0);
    check("m1_evon", 32'(evt_on),   32'h1);
    send(8'h1B);
    check("m2_evt",  32'(evt),      32'h1);
    check("m2_slot", 32'(evt_slot), 32'h1);
    check("m2_on",   32'(voice_on), 32'h3);
    check("m2_key",  voice_key & 32'hFFFF, 32'h1B1C);
    check("m2_held", 32'(held),     32'h2);
    idle();
    check("m2_evt_pulse", 32'(evt), 32'h0);

    // Typematic repeat
    do_reset();
    send(8'h1C);
    check("tm1_evt", 32'(evt), 32'h1);
    send(8'h1C);
    check("tm2_evt", 32'(evt), 32'h0);
    send(8'h1C);
    check("tm3_evt", 32'(evt), 32'h0);
    check("tm_held", 32'(held), 32'h1);
    check("tm_on",   32'(voice_on), 32'h1);

    // Make then break, key retained
    do_reset();
    send(8'h1C);
    send(8'hF0);
    check("br_f0_evt", 32'(evt), 32'h0);
    send(8'h1C);
    check("br_evt",  32'(evt),      32'h1);
    check("br_evon", 32'(evt_on),   32'h0);
    check("br_slot", 32'(evt_slot), 32'h0);
    check("br_key",  voice_key & 32'hFF, 32'h1C);
    check("br_held", 32'(held),     32'h0);

    // Steal the oldest slot once the pool is full
    do_reset();
    send(8'h15); send(8'h1D); send(8'h24); send(8'h2D);
    check("full_on",   32'(voice_on), 32'hF);
    check("full_held", 32'(held),     32'h4);
    check("full_key",  voice_key,     32'h2D241D15);
    send(8'h2C);
    check("st_evt",  32'(evt),      32'h1);
    check("st_slot", 32'(evt_slot), 32'h0);
    check("st_evon", 32'(evt_on),   32'h1);
    check("st_key",  voice_key,     32'h2D241D2C);
    send(8'hF0);
    send(8'h15);
    check("stale_evt",  32'(evt),      32'h0);
    check("stale_on",   32'(voice_on), 32'hF);
    check("stale_slot", 32'(evt_slot), 32'h0);
    check("stale_evon", 32'(evt_on),   32'h1);
    send(8'h33);
    check("st2_slot", 32'(evt_slot), 32'h1);
    check("st2_key",  voice_key,     32'h2D24332C);
    send(8'hF0); send(8'h24);
    check("rel2_evt",  32'(evt),      32'h1);
    check("rel2_slot", 32'(evt_slot), 32'h2);
    check("rel2_evon", 32'(evt_on),   32'h0);
    check("rel2_on",   32'(voice_on), 32'hB);
    send(8'h44);
    check("re_slot", 32'(evt_slot), 32'h2);
    check("re_held", 32'(held),     32'h4);
    check("re_key",  voice_key,     32'h2D44332C);

    // Extended codes are dropped
    do_reset();
    send(8'hE0); send(8'h75);
    check("ext_evt", 32'(evt), 32'h0);
    send(8'hE0); send(8'hF0); send(8'h75);
    check("extb_evt", 32'(evt), 32'h0);
    check("ext_on",   32'(voice_on), 32'h0);
    send(8'h00);
    check("zero_evt", 32'(evt), 32'h0);
    send(8'h1C);
    check("post_ext_evt",  32'(evt),      32'h1);
    check("post_ext_slot", 32'(evt_slot), 32'h0);

    // all_off beats a simultaneous byte
    do_reset();
    send(8'h1C); send(8'h1B); send(8'h15);
    check("ao_pre_held", 32'(held), 32'h3);
    panic(1'b1, 8'h23);
    check("ao_on",   32'(voice_on), 32'h0);
    check("ao_held", 32'(held),     32'h0);
    check("ao_evt",  32'(evt),      32'h0);
    check("ao_key",  voice_key,     32'h00151B1C);
    send(8'h23);
    check("ao_next_slot", 32'(evt_slot), 32'h0);
    check("ao_next_key",  voice_key,     32'h00151B23);
    check("ao_next_held", 32'(held),     32'h1);

    // all_off returns a pending break to IDLE
    do_reset();
    send(8'h1C);
    send(8'hF0);
    panic(1'b0, 8'h00);
    send(8'h1C);
    check("ao_brk_evt",  32'(evt),    32'h1);
    check("ao_brk_evon", 32'(evt_on), 32'h1);

    // Reset in BRK: next byte is a fresh make
    do_reset();
    send(8'hF0);
    do_reset();
    send(8'h1C);
    check("rb_evt",  32'(evt),      32'h1);
    check("rb_evon", 32'(evt_on),   32'h1);
    check("rb_on",   32'(voice_on), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_voice_alloc.md
# ps2_voice_alloc

Polyphonic voice allocator for the ePiano: consumes the raw PS/2 scan-code byte stream (`data`/`ready` from the keyboard receiver) and shares a fixed pool of tone-generator voices between the currently held keys. Each voice slot holds one keycode and an on flag, which the per-voice keycode-to-frequency lookup and tone generators downstream read. When more keys are held than voices exist, the block steals the least-recently-allocated voice.

## Interface
- `VOICES`, 4: number of voice slots; 2..8.
- `clk` input 1: system clock; all state updates on the rising edge.
- `clrn` input 1: asynchronous, active-high reset.
- `data` input 8: scan-code byte from the PS/2 receiver.
- `ready` input 1: `data` valid this cycle. One byte is consumed per cycle where `ready`=1.
- `all_off` input 1: synchronous panic; releases every voice.
- `voice_key` output 8*VOICES: slot i keycode at bits [8i+7:8i].
- `voice_on` output VOICES: slot i sounding.
- `evt` output 1: one-cycle strobe on any voice change caused by a byte.
- `evt_slot` output 3: slot affected by the current `evt`.
- `evt_on` output 1: 1 means allocated or stolen; 0 means released.
- `held` output 4: number of slots with `voice_on`=1.

## Operation
- Parser FSM, one transition per accepted byte:
  - IDLE:
    - 0xF0 goes to BRK.
    - 0xE0 goes to EXT.
    - 0x00 stays in IDLE and is ignored.
    - Any other byte is a MAKE(code) and stays in IDLE.
  - BRK: any byte is a BREAK(code) and goes to IDLE.
  - EXT:
    - 0xF0 goes to EXTBRK.
    - Any other byte goes to IDLE and is dropped.
    - Extended keys are not playable.
  - EXTBRK: any byte goes to IDLE and is dropped.
- MAKE(code):
  - If a slot with `voice_on`=1 already holds `code`, this is typematic repeat. Nothing changes and `evt` is not raised.
  - Otherwise, if any slot is free, allocate the lowest-indexed free slot.
  - Otherwise, steal the slot whose LRU rank is VOICES-1.
  - The chosen slot gets `voice_key`=code and `voice_on`=1, and raises `evt`=1, `evt_on`=1.
- BREAK(code):
  - The slot holding `code` with on=1 gets `voice_on`=0 and raises `evt` with `evt_on`=0.
  - `voice_key` is retained.
  - If no slot matches (the key was already stolen), nothing changes and there is no `evt`.
- LRU rank:
  - Each slot carries a rank from 0 to VOICES-1; ranks are always a permutation.
  - On allocation or steal of slot s with old rank r, every slot with rank < r increments by 1, and slot s gets rank 0.
  - A release does not change ranks.
- `held` equals popcount(`voice_on`), registered together with `voice_on`.
- `all_off` clears all `voice_on` bits and returns the FSM to IDLE. It leaves `voice_key` and ranks unchanged and raises no `evt`.
- If `all_off` and `ready` are high in the same cycle, `all_off` wins and the byte is dropped.

## Timing
- Reset values:
  - FSM in IDLE.
  - `voice_on`=0, `voice_key`=0, `held`=0.
  - `evt`=0, `evt_slot`=0, `evt_on`=0.
  - Slot i rank = i.
- Latency: a byte with `ready`=1 at edge N shows its `voice_*`, `held` and `evt` results registered after edge N. They are visible in cycle N+1.
- `evt` lasts exactly one cycle. `evt_slot` and `evt_on` hold their last values until the next `evt`.
- Back-to-back `ready` cycles are fully supported, with no stall and no backpressure. There is one result per byte, in order.
- When a MAKE and BREAK for the same key arrive on consecutive bytes, each is processed against the state left by the previous byte.
- Reset asserted mid-sequence, for example between 0xF0 and its code, forces IDLE. The next byte is then parsed as a fresh MAKE.
- Slot search, match and rank update are combinational within one cycle, with no multi-cycle paths.

## Test plan
- Reset, then bytes 0x1C, 0x1B (`ready` pulses): slot0=0x1C and slot1=0x1B are on. Two `evt` pulses with `evt_slot`=0 then 1. `held`=2.
- Bytes 0x1C, 0x1C, 0x1C (typematic): one allocation and one `evt` only. `held`=1.
- Bytes 0x1C, 0xF0, 0x1C: slot0 allocates then releases. The second `evt` has `evt_on`=0. `voice_key[7:0]` stays 0x1C and `held`=0.
- With VOICES=4:
  - Make 0x15, 0x1D, 0x24, 0x2D, then 0x2C: 0x2C steals slot0 (oldest), with `evt_slot`=0 and `evt_on`=1.
  - Then 0xF0 0x15: no `evt`, no change.
- Byte sequence 0xE0 0x75, then 0xE0 0xF0 0x75: no voice change and no `evt`. The next 0x1C allocates normally.
- With 3 voices on, `all_off` asserted together with `ready` carrying byte 0x23: `voice_on`=0 and `held`=0 next cycle, and 0x23 is not allocated. Reset during BRK, followed by 0x1C, allocates 0x1C.
